adder_serial_chunk: RTL and testbench

ADDER_SERIAL_CHUNK -- requirements
Module: adder_serial_chunk

---
 rtl/adder_serial_chunk.sv | 104 ++++++++++
 tb/tb_adder_serial_chunk.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/adder_serial_chunk.sv
// Multi-cycle adder/subtractor: processes CHUNK bits per clock, LSB chunk first,
// with a valid/ready handshake on the command and result sides.
module adder_serial_chunk #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CHUNK = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned NumBeats = WIDTH / CHUNK;
    localparam int unsigned CntW     = (NumBeats > 1) ? $clog2(NumBeats) : 1;

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, b_q, sum_q;
    logic             carry_q, cout_q, ovf_q;
    logic [CntW-1:0]  beat_q;
    logic [CHUNK:0]   chunk_res;
    logic             last_beat;
    logic             msb_carry_in;

    always_comb begin
        chunk_res = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]} + {{CHUNK{1'b0}}, carry_q};
        last_beat = (beat_q == CntW'(NumBeats - 1));
        // Operands are shifted down each beat, so on the last beat the MSB sits at CHUNK-1.
        msb_carry_in = a_q[CHUNK-1] ^ b_q[CHUNK-1] ^ chunk_res[CHUNK-1];
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (in_valid)  state_d = StBusy;
            StBusy:  if (last_beat) state_d = StDone;
            StDone:  if (out_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            beat_q  <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        a_q     <= a;
                        b_q     <= sub ? ~b : b;
                        carry_q <= sub | cin;
                        beat_q  <= '0;
                        sum_q   <= '0;
                        cout_q  <= 1'b0;
                        ovf_q   <= 1'b0;
                    end
                end
                StBusy: begin
                    a_q     <= a_q >> CHUNK;
                    b_q     <= b_q >> CHUNK;
                    carry_q <= chunk_res[CHUNK];
                    beat_q  <= beat_q + 1'b1;
                    sum_q[int'(beat_q) * CHUNK +: CHUNK] <= chunk_res[CHUNK-1:0];
                    if (last_beat) begin
                        cout_q <= chunk_res[CHUNK];
                        ovf_q  <= msb_carry_in ^ chunk_res[CHUNK];
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_adder_serial_chunk.sv
// Bench for adder_serial_chunk: directed cases on CHUNK=2 plus a random sweep
// over CHUNK in {1,2,4,8} against an integer-arithmetic reference.
module tb_adder_serial_chunk;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b1;
    logic [7:0] a = '0, b = '0;
    logic       cin = 1'b0, sub = 1'b0;

    logic [7:0] sum_w [4];
    logic       ov_w [4];
    logic       ir_w [4];
    logic       co_w [4];
    logic       of_w [4];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    adder_serial_chunk #(.WIDTH(8), .CHUNK(1)) u_c1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir_w[0]), .a(a), .b(b),
        .cin(cin), .sub(sub), .out_valid(ov_w[0]), .out_ready(out_ready), .sum(sum_w[0]),
        .cout(co_w[0]), .ovf(of_w[0]));
    adder_serial_chunk #(.WIDTH(8), .CHUNK(2)) u_c2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir_w[1]), .a(a), .b(b),
        .cin(cin), .sub(sub), .out_valid(ov_w[1]), .out_ready(out_ready), .sum(sum_w[1]),
        .cout(co_w[1]), .ovf(of_w[1]));
    adder_serial_chunk #(.WIDTH(8), .CHUNK(4)) u_c4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir_w[2]), .a(a), .b(b),
        .cin(cin), .sub(sub), .out_valid(ov_w[2]), .out_ready(out_ready), .sum(sum_w[2]),
        .cout(co_w[2]), .ovf(of_w[2]));
    adder_serial_chunk #(.WIDTH(8), .CHUNK(8)) u_c8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir_w[3]), .a(a), .b(b),
        .cin(cin), .sub(sub), .out_valid(ov_w[3]), .out_ready(out_ready), .sum(sum_w[3]),
        .cout(co_w[3]), .ovf(of_w[3]));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: signed/unsigned integer arithmetic, independent of chunking.
    task automatic ref_model(input logic [7:0] ra, input logic [7:0] rb, input logic rc,
                             input logic rs, output logic [7:0] es, output logic ec,
                             output logic eo);
        int ures, sres;
        if (rs) begin
            ures = int'(ra) - int'(rb);
            sres = int'($signed(ra)) - int'($signed(rb));
            ec   = (ra >= rb);
        end else begin
            ures = int'(ra) + int'(rb) + int'(rc);
            sres = int'($signed(ra)) + int'($signed(rb)) + int'(rc);
            ec   = (ures > 255);
        end
        es = 8'(ures);
        eo = (sres > 127) || (sres < -128);
    endtask

    // Issue one command; returns edges from accept until CHUNK=2 out_valid is seen.
    task automatic issue_main(input logic [7:0] ta, input logic [7:0] tb_v, input logic tc,
                              input logic ts, output int lat);
        a = ta; b = tb_v; cin = tc; sub = ts; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!ov_w[1] && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic directed(input string tag, input logic [7:0] ta, input logic [7:0] tb_v,
                            input logic tc, input logic ts, input logic [7:0] es,
                            input logic ec, input logic eo);
        int lat;
        issue_main(ta, tb_v, tc, ts, lat);
        check({tag, "_lat"}, lat, 5);
        check({tag, "_sum"}, sum_w[1], es);
        check({tag, "_cout"}, co_w[1], ec);
        check({tag, "_ovf"}, of_w[1], eo);
        repeat (8) @(posedge clk);
        #1;
    endtask

    task automatic run_rand();
        logic [7:0] es;
        logic ec, eo;
        bit   seen [4];
        a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom); sub = 1'($urandom);
        ref_model(a, b, cin, sub, es, ec, eo);
        for (int k = 0; k < 4; k++) seen[k] = 1'b0;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom); sub = 1'($urandom);
        for (int cyc = 1; cyc <= 12; cyc++) begin
            for (int k = 0; k < 4; k++) begin
                if (!seen[k] && ov_w[k]) begin
                    seen[k] = 1'b1;
                    check("rnd_lat", cyc, 8 / (1 << k) + 1);
                    check("rnd_sum", sum_w[k], es);
                    check("rnd_cout", co_w[k], ec);
                    check("rnd_ovf", of_w[k], eo);
                end
            end
            @(posedge clk); #1;
        end
        for (int k = 0; k < 4; k++) begin
            check("rnd_seen", seen[k], 1'b1);
            check("rnd_idle", ir_w[k], 1'b1);
        end
    endtask

    initial begin
        int lat;
        logic [7:0] held;

        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", ir_w[1], 1'b1);
        check("rst_out_valid", ov_w[1], 1'b0);
        check("rst_sum", sum_w[1], 8'h00);
        check("rst_cout", co_w[1], 1'b0);
        check("rst_ovf", of_w[1], 1'b0);
        rst = 1'b0;
        @(posedge clk); #1;

        directed("add_0f_01", 8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0);
        directed("add_7f_01", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
        directed("add_ff_01", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        directed("sub_00_01", 8'h00, 8'h01, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0);
        directed("sub_80_01", 8'h80, 8'h01, 1'b1, 1'b1, 8'h7F, 1'b1, 1'b1);
        directed("add_cin", 8'h10, 8'h20, 1'b1, 1'b0, 8'h31, 1'b0, 1'b0);

        // Backpressure: hold result for 10 cycles while a new command is offered.
        out_ready = 1'b0;
        issue_main(8'h12, 8'h34, 1'b0, 1'b0, lat);
        check("bp_lat", lat, 5);
        held = sum_w[1];
        check("bp_sum", held, 8'h46);
        a = 8'hAA; b = 8'h55; in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("bp_valid", ov_w[1], 1'b1);
            check("bp_held", sum_w[1], 8'h46);
            check("bp_in_ready", ir_w[1], 1'b0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("bp_return_ready", ir_w[1], 1'b1);
        check("bp_return_valid", ov_w[1], 1'b0);
        repeat (10) @(posedge clk);
        #1;

        // Reset mid-BUSY at beat 2 of 4.
        a = 8'hF0; b = 8'h0F; cin = 1'b1; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("mid_busy", ir_w[1], 1'b0);
        rst = 1'b1;
        #1;
        check("mrst_out_valid", ov_w[1], 1'b0);
        check("mrst_sum", sum_w[1], 8'h00);
        check("mrst_cout", co_w[1], 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("mrst_in_ready", ir_w[1], 1'b1);
        directed("after_rst", 8'h03, 8'h04, 1'b0, 1'b0, 8'h07, 1'b0, 1'b0);

        for (int n = 0; n < 1000; n++) run_rand();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
